// File: rtl/nibble_parity_rx.sv
// Serial receiver for start / 4 data / parity / stop nibble frames with parity and framing checks.
// Optional parity-error counter enabled by defining NIBBLE_PARITY_RX_ERR_CNT_EN.
module nibble_parity_rx #(
    parameter bit PARITY_ODD = 1'b0,
    parameter bit IDLE_LVL   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit_en,
    input  logic       i_ser,
    output logic [3:0] o_data,
    output logic       o_valid,
    output logic       o_par_err,
    output logic       o_frm_err,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t     state_r, state_next_s;
    logic [1:0] cnt_r, cnt_next_s;
    logic [3:0] shift_r, shift_next_s;
    logic       rp_r, rp_next_s;
    logic       ep_r, ep_next_s;
    logic       rearm_r, rearm_next_s;
    logic [3:0] data_r, data_next_s;
    logic       valid_r, valid_next_s;
    logic       par_err_r, par_err_next_s;
    logic       frm_err_r, frm_err_next_s;
    logic       busy_r, busy_next_s;

    function automatic logic exp_parity(input logic [3:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 2'd0;
            shift_r   <= 4'd0;
            rp_r      <= 1'b0;
            ep_r      <= 1'b0;
            rearm_r   <= 1'b0;
            data_r    <= 4'd0;
            valid_r   <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            shift_r   <= shift_next_s;
            rp_r      <= rp_next_s;
            ep_r      <= ep_next_s;
            rearm_r   <= rearm_next_s;
            data_r    <= data_next_s;
            valid_r   <= valid_next_s;
            par_err_r <= par_err_next_s;
            frm_err_r <= frm_err_next_s;
            busy_r    <= busy_next_s;
        end
    end

    // Next-state and strobe logic; strobes default low so each lasts one clock.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        shift_next_s   = shift_r;
        rp_next_s      = rp_r;
        ep_next_s      = ep_r;
        rearm_next_s   = rearm_r;
        data_next_s    = data_r;
        valid_next_s   = 1'b0;
        par_err_next_s = 1'b0;
        frm_err_next_s = 1'b0;
        if (i_bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    // After a framing error the line must go idle before a new start is honoured.
                    if (rearm_r) begin
                        rearm_next_s = (i_ser != IDLE_LVL);
                    end else if (i_ser != IDLE_LVL) begin
                        state_next_s = ST_DATA;
                        cnt_next_s   = 2'd0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_next_s = {shift_r[2:0], i_ser};
                    cnt_next_s   = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    rp_next_s    = i_ser;
                    ep_next_s    = exp_parity(shift_r, PARITY_ODD);
                    state_next_s = ST_STOP;
                end
                ST_STOP: begin
                    if (i_ser == IDLE_LVL) begin
                        data_next_s    = shift_r;
                        valid_next_s   = 1'b1;
                        par_err_next_s = rp_r ^ ep_r;
                        rearm_next_s   = 1'b0;
                    end else begin
                        frm_err_next_s = 1'b1;
                        rearm_next_s   = 1'b1;
                    end
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
        busy_next_s = (state_next_s != ST_IDLE);
    end

`ifdef NIBBLE_PARITY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating parity-error counter, advanced on the edge that raises the error strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (valid_next_s && par_err_next_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign o_err_cnt = err_cnt_r;
`else
    assign o_err_cnt = 8'h00;
`endif

    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_par_err = par_err_r;
    assign o_frm_err = frm_err_r;
    assign o_busy    = busy_r;

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Directed self-checking bench for nibble_parity_rx (default parameters: even parity, idle-high line).
module tb_nibble_parity_rx;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_bit_en;
    logic       i_ser;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_par_err;
    logic       o_frm_err;
    logic       o_busy;
    logic [7:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

`ifdef NIBBLE_PARITY_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    nibble_parity_rx dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_bit_en (i_bit_en),
        .i_ser    (i_ser),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_par_err(o_par_err),
        .o_frm_err(o_frm_err),
        .o_busy   (o_busy),
        .o_err_cnt(o_err_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Strobe monitor, sampled mid-cycle.
    int n_tick = 0;
    int n_valid = 0, n_par = 0, n_frm = 0, n_wide = 0, n_mix = 0;
    int last_vtick = 0, prev_vtick = 0;
    logic v_prev = 1'b0;

    always @(posedge i_clk) begin
        if (i_bit_en) n_tick <= n_tick + 1;
    end

    always @(negedge i_clk) begin
        v_prev <= o_valid;
        if (o_valid) begin
            n_valid    <= n_valid + 1;
            prev_vtick <= last_vtick;
            last_vtick <= n_tick;
        end
        if (o_valid && v_prev) n_wide <= n_wide + 1;
        if (o_par_err) n_par <= n_par + 1;
        if (o_frm_err) n_frm <= n_frm + 1;
        if ((o_par_err && !o_valid) || (o_frm_err && o_valid)) n_mix <= n_mix + 1;
    end

    // One bit on the line: a tick edge, then gap-1 clocks with no tick.
    task automatic tick(input logic b, input int gap);
        i_ser    = b;
        i_bit_en = 1'b1;
        @(posedge i_clk);
        #1;
        i_bit_en = 1'b0;
        for (int k = 1; k < gap; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop, input int gap);
        tick(1'b0, gap);
        for (int i = 3; i >= 0; i--) tick(d[i], gap);
        tick(p, gap);
        tick(stop, gap);
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_bit_en = 1'b0;
        i_ser    = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        total++;
        if ({o_data, o_valid, o_par_err, o_frm_err, o_busy} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000000", {o_data, o_valid, o_par_err, o_frm_err, o_busy});
        end
        total++;
        if (o_err_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_err_cnt: got %h want 00", o_err_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic();
        send_frame(4'b1011, 1'b1, 1'b1, 1);
        total++;
        if ({o_valid, o_par_err, o_frm_err, o_busy} !== 4'b1000) begin
            bad++;
            $display("FAIL basic_strobes: got v/p/f/b=%b want 1000", {o_valid, o_par_err, o_frm_err, o_busy});
        end
        total++;
        if (o_data !== 4'b1011) begin
            bad++;
            $display("FAIL basic_data: got %b want 1011", o_data);
        end
        tick(1'b1, 1);
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_one_cycle: got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_par_err();
        send_frame(4'b1011, 1'b0, 1'b1, 1);
        total++;
        if ({o_valid, o_par_err, o_frm_err} !== 3'b110) begin
            bad++;
            $display("FAIL par_err_strobes: got v/p/f=%b want 110", {o_valid, o_par_err, o_frm_err});
        end
        total++;
        if (o_data !== 4'b1011) begin
            bad++;
            $display("FAIL par_err_data: got %b want 1011", o_data);
        end
        total++;
        if (o_err_cnt !== (CNT_EN ? 8'h01 : 8'h00)) begin
            bad++;
            $display("FAIL par_err_cnt: got %h want %h", o_err_cnt, (CNT_EN ? 8'h01 : 8'h00));
        end
        tick(1'b1, 1);
    endtask

    task automatic test_frm_err();
        int f0 = n_frm;
        send_frame(4'b0110, 1'b0, 1'b0, 1);
        total++;
        if ({o_valid, o_frm_err} !== 2'b01) begin
            bad++;
            $display("FAIL frm_err_strobes: got v/f=%b want 01", {o_valid, o_frm_err});
        end
        total++;
        if (o_data !== 4'b1011) begin
            bad++;
            $display("FAIL frm_err_data_kept: got %b want 1011", o_data);
        end
        repeat (3) tick(1'b0, 1);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL frm_err_no_restart: got busy=%b want 0", o_busy);
        end
        tick(1'b1, 1);
        tick(1'b0, 1);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL frm_err_rearm: got busy=%b want 1", o_busy);
        end
        tick(1'b0, 1); tick(1'b0, 1); tick(1'b0, 1); tick(1'b1, 1);
        tick(1'b1, 1);
        tick(1'b1, 1);
        total++;
        if ({o_valid, o_data} !== 5'b10001) begin
            bad++;
            $display("FAIL frm_err_recover: got v,data=%b want 10001", {o_valid, o_data});
        end
        tick(1'b1, 1);
        total++;
        if (n_frm - f0 !== 1) begin
            bad++;
            $display("FAIL frm_err_count: got %0d want 1", n_frm - f0);
        end
    endtask

    task automatic test_back_to_back(input int gap);
        int v0 = n_valid;
        int p0 = n_par;
        int f0 = n_frm;
        int w0 = n_wide;
        send_frame(4'b0001, 1'b1, 1'b1, gap);
        send_frame(4'b1111, 1'b0, 1'b1, gap);
        tick(1'b1, gap);
        total++;
        if (n_valid - v0 !== 2) begin
            bad++;
            $display("FAIL b2b_gap%0d_valid_count: got %0d want 2", gap, n_valid - v0);
        end
        total++;
        if (last_vtick - prev_vtick !== 7) begin
            bad++;
            $display("FAIL b2b_gap%0d_spacing: got %0d want 7", gap, last_vtick - prev_vtick);
        end
        total++;
        if ((n_par - p0) + (n_frm - f0) + (n_wide - w0) !== 0) begin
            bad++;
            $display("FAIL b2b_gap%0d_errors: got %0d want 0", gap, (n_par - p0) + (n_frm - f0) + (n_wide - w0));
        end
        total++;
        if (o_data !== 4'b1111) begin
            bad++;
            $display("FAIL b2b_gap%0d_data: got %b want 1111", gap, o_data);
        end
    endtask

    task automatic test_mid_reset();
        int v0;
        tick(1'b0, 1);
        tick(1'b0, 1);
        tick(1'b1, 1);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_busy_before: got %b want 1", o_busy);
        end
        v0 = n_valid;
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_data, o_err_cnt} !== 13'd0) begin
            bad++;
            $display("FAIL mid_reset_async: got busy,data,cnt=%b want 0", {o_busy, o_data, o_err_cnt});
        end
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        send_frame(4'b0110, 1'b0, 1'b1, 1);
        total++;
        if ({o_valid, o_par_err, o_data} !== 6'b100110) begin
            bad++;
            $display("FAIL mid_reset_frame: got v,p,data=%b want 100110", {o_valid, o_par_err, o_data});
        end
        tick(1'b1, 1);
        total++;
        if (n_valid - v0 !== 1) begin
            bad++;
            $display("FAIL mid_reset_valid_count: got %0d want 1", n_valid - v0);
        end
    endtask

    task automatic test_err_sat();
        int p0 = n_par;
        for (int n = 0; n < 255; n++) send_frame(4'b1011, 1'b0, 1'b1, 1);
        tick(1'b1, 1);
        total++;
        if (o_err_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            bad++;
            $display("FAIL err_cnt_255: got %h want %h", o_err_cnt, (CNT_EN ? 8'hFF : 8'h00));
        end
        for (int n = 0; n < 5; n++) send_frame(4'b1011, 1'b0, 1'b1, 1);
        tick(1'b1, 1);
        total++;
        if (o_err_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            bad++;
            $display("FAIL err_cnt_sat: got %h want %h", o_err_cnt, (CNT_EN ? 8'hFF : 8'h00));
        end
        total++;
        if (n_par - p0 !== 260) begin
            bad++;
            $display("FAIL err_sat_par_pulses: got %0d want 260", n_par - p0);
        end
    endtask

    task automatic test_invariants();
        total++;
        if (n_mix !== 0) begin
            bad++;
            $display("FAIL strobe_exclusivity: got %0d want 0", n_mix);
        end
        total++;
        if (n_wide !== 0) begin
            bad++;
            $display("FAIL strobe_width: got %0d want 0", n_wide);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_par_err();
        test_frm_err();
        test_back_to_back(1);
        test_back_to_back(4);
        test_mid_reset();
        test_err_sat();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
